// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, common command bytes and the
// odd-parity helper used by both the transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Returns the bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an idle-high PS/2 line plus a falling-edge strobe
// that is high for one cycle when the synchronized value goes 1 -> 0.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts out data/parity/stop on device clock falling edges and checks the ACK.
// Handshake: a cycle with tx_start=1 and tx_ready=1 accepts tx_data; exactly one
// of tx_done or tx_error pulses for one cycle when that frame ends.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe,
  output logic [2:0] state_dbg
);

  localparam int INHIBIT_CYCLES = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WDG_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e       state_q, state_d;
  logic [8:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [WDG_W-1:0] wdg_q, wdg_d;
  logic             data_oe_q, data_oe_d;
  logic             dmeta_q, dmeta_d;
  logic             dsync_q, dsync_d;

  logic       clk_sync;
  logic       clk_fall;
  logic       wdg_active;
  logic [3:0] nxt_idx;

  ps2_sync_edge u_clk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (PS2_clk),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  assign wdg_active = (state_q == ST_RTS) || (state_q == ST_SHIFT) ||
                      (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign nxt_idx    = bit_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    inh_d      = inh_q;
    wdg_d      = wdg_q;
    data_oe_d  = data_oe_q;
    dmeta_d    = PS2_data;
    dsync_d    = dmeta_q;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    PS2_clk_oe = 1'b0;

    if (wdg_active && (wdg_q == '0)) begin
      state_d   = ST_IDLE;
      data_oe_d = 1'b0;
      tx_error  = 1'b1;
    end else begin
      if (wdg_active) wdg_d = wdg_q - WDG_W'(1);
      case (state_q)
        ST_IDLE: begin
          data_oe_d = 1'b0;
          if (tx_start) begin
            frame_d = {odd_parity(tx_data), tx_data};
            inh_d   = INH_W'(INHIBIT_CYCLES);
            state_d = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          PS2_clk_oe = 1'b1;
          if (inh_q <= INH_W'(1)) begin
            state_d   = ST_RTS;
            data_oe_d = 1'b1;
            wdg_d     = WDG_W'(TIMEOUT_CYCLES);
          end else begin
            inh_d = inh_q - INH_W'(1);
          end
        end
        ST_RTS: begin
          if (clk_fall) begin
            data_oe_d = ~frame_q[0];
            bit_cnt_d = 4'd0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // bit_cnt_q is the frame bit on the line; 8 means parity is showing.
          if (clk_fall) begin
            if (bit_cnt_q == 4'd8) begin
              data_oe_d = 1'b0;
              state_d   = ST_ACK;
            end else begin
              data_oe_d = ~frame_q[nxt_idx];
              bit_cnt_d = nxt_idx;
            end
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            if (!dsync_q) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              tx_error = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_sync && dsync_q) begin
            tx_done = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          data_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_q     <= '0;
      wdg_q     <= '0;
      data_oe_q <= 1'b0;
      dmeta_q   <= 1'b1;
      dsync_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_q     <= inh_d;
      wdg_q     <= wdg_d;
      data_oe_q <= data_oe_d;
      dmeta_q   <= dmeta_d;
      dsync_q   <= dsync_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign PS2_data_oe = data_oe_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx at 1 MHz: a device model clocks frames, a queue holds
// the expected line bits per edge, and pulse counters track done/error.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 20;
  localparam int INH_EXP = 100;
  localparam int TMO_EXP = 15000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready, tx_done, tx_error;
  logic       PS2_clk_oe, PS2_data_oe;
  logic [2:0] state_dbg;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       line_clk, line_data;

  assign line_clk  = dev_clk & ~PS2_clk_oe;
  assign line_data = dev_data & ~PS2_data_oe;

  ps2_host_tx #(.CLK_FREQ(1_000_000), .INHIBIT_US(100), .TIMEOUT_MS(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .PS2_clk     (line_clk),
    .PS2_data    (line_data),
    .PS2_clk_oe  (PS2_clk_oe),
    .PS2_data_oe (PS2_data_oe),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;
  int inh_run = 0;
  int inh_len = 0;
  int exp_done_total = 0;
  int exp_err_total = 0;
  logic [0:0] exp_q[$];

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) overlap++;
    if (PS2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic calc_par(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic accept(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", tx_ready, 1);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    check("busy_after_accept", tx_ready, 0);
  endtask

  task automatic push_frame(input logic [7:0] b, input logic par);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  task automatic wait_rts();
    int n;
    n = 0;
    while (!(PS2_data_oe && !PS2_clk_oe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rts_reached", int'(PS2_data_oe && !PS2_clk_oe), 1);
  endtask

  // Device clocks falling edges first..last; samples the line late in each low phase.
  task automatic dev_edges(input int first, input int last, input logic ack);
    logic [0:0] e;
    for (int k = first; k <= last; k++) begin
      if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k <= 10) begin
        if (exp_q.size() == 0) check("frame_bit_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("frame_bit", int'(line_data), int'(e));
        end
      end
      dev_clk = 1'b1;
    end
    if (last == 11) begin
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic do_send(input logic [7:0] b, input logic ack, input logic par,
                         input int poke_at);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(b);
    push_frame(b, par);
    wait_rts();
    @(negedge clk);
    check("inhibit_len", inh_len, INH_EXP);
    check("start_bit", int'(line_data), 0);
    if (poke_at > 0) begin
      dev_edges(1, poke_at, ack);
      tx_data  = 8'h00;
      tx_start = 1'b1;
      @(negedge clk);
      check("ready_low_in_shift", tx_ready, 0);
      tx_start = 1'b0;
      dev_edges(poke_at + 1, 11, ack);
    end else begin
      dev_edges(1, 11, ack);
    end
    if (ack) begin
      n = 0;
      while (!tx_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", tx_done, 1);
      @(negedge clk);
      check("ready_after_done", tx_ready, 1);
    end
    repeat (5) @(negedge clk);
    check("done_count", done_cnt - d0, int'(ack));
    check("error_count", err_cnt - e0, int'(!ack));
    check("oe_released", int'({PS2_clk_oe, PS2_data_oe}), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    if (ack) exp_done_total++;
    else exp_err_total++;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, d0, e0;
    logic [7:0] r;

    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_oe", int'({PS2_clk_oe, PS2_data_oe}), 0);
    check("rst_pulses", int'({tx_done, tx_error}), 0);
    check("rst_state", int'(state_dbg), int'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = '{CMD_SET_LEDS, 1'b1, 1'b1};
    vecs[1] = '{CMD_ENABLE,   1'b1, 1'b0};
    vecs[2] = '{CMD_RESET,    1'b1, 1'b1};
    vecs[3] = '{8'h00,        1'b1, 1'b1};
    r = 8'($urandom_range(0, 255));
    vecs[4] = '{r, 1'b1, calc_par(r)};
    r = 8'($urandom_range(0, 255));
    vecs[5] = '{r, 1'b1, calc_par(r)};
    vecs[6] = '{CMD_SET_LEDS, 1'b0, 1'b1};

    for (int i = 0; i < 7; i++) do_send(vecs[i].data, vecs[i].ack, vecs[i].par, 0);

    // Stray request mid-frame must not disturb the byte being shifted.
    do_send(CMD_SET_LEDS, 1'b1, 1'b1, 4);

    // Device never clocks: watchdog fires a fixed number of cycles after RTS.
    d0 = done_cnt;
    accept(CMD_ENABLE);
    wait_rts();
    n = 0;
    while (!tx_error && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO_EXP);
    @(negedge clk);
    check("timeout_oe_released", int'({PS2_clk_oe, PS2_data_oe}), 0);
    check("timeout_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    check("timeout_no_done", done_cnt - d0, 0);
    exp_err_total++;

    // Reset after the fifth edge, then a normal frame.
    accept(CMD_SET_LEDS);
    push_frame(CMD_SET_LEDS, 1'b1);
    wait_rts();
    dev_edges(1, 5, 1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    #1;
    check("midrst_oe", int'({PS2_clk_oe, PS2_data_oe}), 0);
    check("midrst_ready", tx_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", int'({tx_done, tx_error}), 0);
    end
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_error", err_cnt - e0, 0);
    do_send(CMD_RESET, 1'b1, 1'b1, 0);

    check("total_done", done_cnt, exp_done_total);
    check("total_error", err_cnt, exp_err_total);
    check("done_error_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, master clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 100, clock-inhibit time before request-to-send, in microseconds.
REQ-003 Parameter TIMEOUT_MS, default 15, watchdog limit from request-to-send to ACK, in milliseconds.
REQ-004 clk  input  1  master clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tx_data  input  8  command byte (e.g. 0xED set LEDs, 0xFF reset); sampled only on accept.
REQ-007 tx_start  input  1  request; accepted only when tx_ready=1.
REQ-008 tx_ready  output  1  high only in IDLE.
REQ-009 tx_done  output  1  one-cycle pulse on ACKed completion.
REQ-010 tx_error  output  1  one-cycle pulse on missing ACK or timeout.
REQ-011 PS2_clk  input  1  device clock line, asynchronous.
REQ-012 PS2_data  input  1  data line, asynchronous.
REQ-013 PS2_clk_oe  output  1  1 = pull clock line low, 0 = release.
REQ-014 PS2_data_oe  output  1  1 = pull data line low, 0 = release.

Function
REQ-015 PS2_clk and PS2_data SHALL pass a 2-flop synchronizer; a falling edge is sync_clk 1->0 between consecutive cycles.
REQ-016 States SHALL be IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe=0; tx_start=1 latches tx_data, computes odd parity, loads INHIBIT_CYCLES = CLK_FREQ/1_000_000*INHIBIT_US, enters INHIBIT next cycle.
REQ-018 INHIBIT: PS2_clk_oe=1, PS2_data_oe=0 for exactly INHIBIT_CYCLES cycles; then RTS.
REQ-019 RTS: PS2_clk_oe=0, PS2_data_oe=1 (start bit 0); watchdog starts at TIMEOUT_CYCLES = CLK_FREQ/1000*TIMEOUT_MS; first falling edge enters SHIFT with bit index 0.
REQ-020 SHIFT: on falling edges 1..8 present data bits 0..7 LSB first, edge 9 parity, edge 10 stop (released); PS2_data_oe = NOT current bit, changed only on a falling edge.
REQ-021 Parity SHALL make total ones in data+parity odd.
REQ-022 ACK: on falling edge 11 sample sync_data; 0 -> WAIT_IDLE, 1 -> pulse tx_error, return IDLE.
REQ-023 WAIT_IDLE: when sync_clk=1 and sync_data=1, pulse tx_done, return IDLE.
REQ-024 Watchdog expiry in RTS, SHIFT, ACK or WAIT_IDLE SHALL release both lines, pulse tx_error, return IDLE the same cycle.
REQ-025 tx_start while tx_ready=0 SHALL be ignored; tx_data changes after accept SHALL not affect the frame.
REQ-026 tx_done and tx_error SHALL never assert in the same cycle.
REQ-027 Counter widths SHALL be $clog2 of their maximum loads; no wrap-around occurs.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, both oe=0, tx_ready=1, tx_done=0, tx_error=0, counters and synchronizers cleared, synchronizers to 1 (idle-high lines).
REQ-029 rst mid-frame SHALL release both lines asynchronously; no done or error pulse follows.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum, the command constants (0xED, 0xF4, 0xFF) and the odd-parity function, shared with the receive path.
REQ-031 Sub-module ps2_sync_edge (2-flop synchronizer plus falling-edge detect) SHALL be instantiated for the clock line and reused by the receiver.

Verification
REQ-032 CLK_FREQ=1_000_000, send 0xED, device model ACKs -> clock held low 100 cycles; bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done.
REQ-033 Send 0xF4 -> parity 0 on edge 9; tx_done pulse; tx_ready high the cycle after.
REQ-034 Device does not ACK (data high at edge 11) -> one tx_error, no tx_done, both oe=0.
REQ-035 Device never clocks after RTS -> tx_error exactly TIMEOUT_CYCLES=15000 cycles after RTS entry.
REQ-036 rst asserted after edge 5 -> both oe=0 within the same cycle, tx_ready=1, no pulses; following 0xFF send completes normally.
REQ-037 tx_start pulsed during SHIFT with 0x00 -> ignored; frame in flight keeps original byte.
